// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  // Operand width limits for the WIDTH parameter.
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor.
//
// Handshake: the master raises start with a and b valid. The slave accepts
// the request on any rising edge where it is idle (busy=0 and not in its done
// cycle). busy is high from the cycle after acceptance until the result is
// ready. done then pulses for exactly one cycle, and diff/borrow_out/ovf are
// valid from that cycle. The results hold until the next done. start seen
// while the slave is busy or done is dropped, not queued. Holding start high
// issues back-to-back operations, and a/b are re-sampled at each acceptance.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, ovf
  );

endinterface

// File: rtl/fullsub_bit.sv
// One-bit full subtractor: d = x - y - bin, with the borrow going out on bout.
module fullsub_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow: borrow when y exceeds x, or on a tie with borrow in.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor. It computes diff = a - b, LSB first,
// one bit per clock, and uses a single full-subtractor cell plus a borrow
// flip-flop. An operation takes WIDTH+2 cycles from the start cycle to the
// first cycle in which a new start can be accepted.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  serial_subtractor_if.slave bus,
  output state_t dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr_a;
  logic [WIDTH-1:0] sr_b;
  logic [WIDTH-1:0] sr_d;
  logic             br;
  logic             a_msb;
  logic             b_msb;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;

  logic             cell_d;
  logic             cell_bout;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] d_next;

  fullsub_bit u_cell (
    .x    (sr_a[0]),
    .y    (sr_b[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Decode handshake events and the next sr_d value.
  always_comb begin
    accept   = (state == IDLE) && bus.start;
    last_bit = (state == RUN) && (cnt == CNT_LAST);
    d_next   = {cell_d, sr_d[WIDTH-1:1]};
  end

  // State register. Reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. DONE always lasts exactly one cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = RUN;
      RUN:     if (cnt == CNT_LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, then one shift of both operands and the result per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_a  <= '0;
      sr_b  <= '0;
      sr_d  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (accept) begin
      sr_a  <= bus.a;
      sr_b  <= bus.b;
      sr_d  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end else if (state == RUN) begin
      sr_a <= sr_a >> 1;
      sr_b <= sr_b >> 1;
      sr_d <= d_next;
      br   <= cell_bout;
      // Hold at the last count rather than wrapping.
      if (cnt != CNT_LAST) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Result registers. They load on the edge into DONE, so the values are valid alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (last_bit) begin
      diff_q   <= d_next;
      borrow_q <= cell_bout;
      ovf_q    <= (a_msb != b_msb) && (cell_d != a_msb);
    end
  end

  // Drive the bus outputs from the state decode and the result registers.
  always_comb begin
    bus.busy       = (state == RUN);
    bus.done       = (state == DONE);
    bus.diff       = diff_q;
    bus.borrow_out = borrow_q;
    bus.ovf        = ovf_q;
    dbg_state      = state;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 8;
  localparam int DONE_LIMIT = 40;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n;
  state_t dbg_state;
  int     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W+1:0] exp_q[$];   // {borrow_out, ovf, diff}
  logic [W+1:0] last_res;

  // Reference model: plain integer subtraction.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] d;
    logic bo;
    logic ov;
    d  = av - bv;
    bo = (av < bv);
    ov = (av[W-1] != bv[W-1]) && (d[W-1] != av[W-1]);
    return {bo, ov, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_ctrl: busy/done=%b required 00", {bus.busy, bus.done});
    end
    total++;
    if ({bus.borrow_out, bus.ovf, bus.diff} !== '0) begin
      bad++;
      $display("FAIL reset_result: got %h required 0", {bus.borrow_out, bus.ovf, bus.diff});
    end
    total++;
    if (dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One operation with a one-cycle start. Checks latency, busy span, result and single done pulse.
  task automatic run_one(input logic [W-1:0] av, input logic [W-1:0] bv, input string name);
    int cycles;
    int busy_cnt;
    bit seen;
    logic [W+1:0] exp_v;
    logic [W+1:0] act;
    cycles   = 0;
    busy_cnt = 0;
    seen     = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    exp_q.push_back(model(av, bv));
    while (!seen && cycles < DONE_LIMIT) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) seen = 1;
    end
    exp_v = exp_q.pop_front();
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout: no done in %0d cycles, required one at %0d", name, cycles, W + 1);
    end else begin
      total++;
      if (cycles !== W + 1) begin
        bad++;
        $display("FAIL %s_latency: done after %0d cycles required %0d", name, cycles, W + 1);
      end
      total++;
      if (busy_cnt !== W) begin
        bad++;
        $display("FAIL %s_busy: busy for %0d cycles required %0d", name, busy_cnt, W);
      end
      act = {bus.borrow_out, bus.ovf, bus.diff};
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL %s_result: {bo,ovf,diff}=%h required %h", name, act, exp_v);
      end
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0 || {bus.borrow_out, bus.ovf, bus.diff} !== exp_v) begin
        bad++;
        $display("FAIL %s_hold: done=%b result=%h required done=0 result=%h",
                 name, bus.done, {bus.borrow_out, bus.ovf, bus.diff}, exp_v);
      end
      last_res = exp_v;
    end
  endtask

  task automatic test_arith();
    run_one(8'd100, 8'd37, "basic");
    run_one(8'd5,   8'd9,  "neg");
    run_one(8'h80,  8'h01, "ovf_pos");
    run_one(8'h7F,  8'hFF, "ovf_neg");
    run_one(8'hFF,  8'hFF, "equal");
    run_one(8'h00,  8'h00, "zero");
    for (int i = 0; i < 3; i++) begin
      run_one(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), "rand");
    end
  endtask

  // start pulsed during RUN must be dropped.
  task automatic test_ignore_start();
    int cycles;
    int done_cnt;
    bit seen;
    logic [W+1:0] exp_v;
    logic [W+1:0] act;
    cycles   = 0;
    done_cnt = 0;
    seen     = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h3C;
    bus.b     = 8'h11;
    exp_q.push_back(model(8'h3C, 8'h11));
    while (!seen && cycles < DONE_LIMIT) begin
      @(negedge clk);
      cycles++;
      bus.start = (cycles == 3);
      if (cycles == 3) begin
        bus.a = 8'h01;
        bus.b = 8'hF0;
      end
      if (bus.done) seen = 1;
    end
    exp_v = exp_q.pop_front();
    total++;
    if (!seen || cycles !== W + 1) begin
      bad++;
      $display("FAIL ignore_latency: seen=%0d cycles=%0d required done at %0d", seen, cycles, W + 1);
    end
    act = {bus.borrow_out, bus.ovf, bus.diff};
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL ignore_result: {bo,ovf,diff}=%h required %h", act, exp_v);
    end
    last_res = exp_v;
    repeat (2 * W) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    total++;
    if (done_cnt !== 0) begin
      bad++;
      $display("FAIL ignore_extra_done: %0d extra done pulses required 0", done_cnt);
    end
  endtask

  // Reset mid-RUN aborts the operation with no done.
  task automatic test_reset_mid_run();
    int done_cnt;
    done_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h55;
    bus.b     = 8'h22;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.busy !== 1'b1 || {bus.borrow_out, bus.ovf, bus.diff} !== last_res) begin
      bad++;
      $display("FAIL midrun_hold: busy=%b result=%h required busy=1 result=%h",
               bus.busy, {bus.borrow_out, bus.ovf, bus.diff}, last_res);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.borrow_out, bus.ovf, bus.diff} !== '0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL midrun_reset: outputs=%h state=%0d required 0 and IDLE",
               {bus.busy, bus.done, bus.borrow_out, bus.ovf, bus.diff}, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * W) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    total++;
    if (done_cnt !== 0) begin
      bad++;
      $display("FAIL midrun_no_done: %0d done pulses after abort required 0", done_cnt);
    end
    run_one(8'h20, 8'h30, "after_reset");
  endtask

  // start held high: three operations, each one sampling its own operands.
  task automatic test_back_to_back();
    logic [W-1:0] ops_a[3];
    logic [W-1:0] ops_b[3];
    int prev_cyc;
    int cycles;
    bit seen;
    logic [W+1:0] exp_v;
    logic [W+1:0] act;
    ops_a[0] = 8'd200; ops_b[0] = 8'd55;
    ops_a[1] = 8'd10;  ops_b[1] = 8'd20;
    ops_a[2] = 8'h81;  ops_b[2] = 8'h7E;
    prev_cyc = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ops_a[0];
    bus.b     = ops_b[0];
    exp_q.push_back(model(ops_a[0], ops_b[0]));
    for (int i = 0; i < 3; i++) begin
      cycles = 0;
      seen   = 0;
      while (!seen && cycles < DONE_LIMIT) begin
        @(negedge clk);
        cycles++;
        if (bus.busy) seen = 1;
      end
      total++;
      if (!seen) begin
        bad++;
        $display("FAIL b2b_accept%0d: not accepted in %0d cycles", i, cycles);
      end
      if (i < 2) begin
        bus.a = ops_a[i+1];
        bus.b = ops_b[i+1];
        exp_q.push_back(model(ops_a[i+1], ops_b[i+1]));
      end
      cycles = 0;
      seen   = 0;
      while (!seen && cycles < DONE_LIMIT) begin
        @(negedge clk);
        cycles++;
        if (bus.done) seen = 1;
      end
      exp_v = exp_q.pop_front();
      act   = {bus.borrow_out, bus.ovf, bus.diff};
      total++;
      if (!seen || act !== exp_v) begin
        bad++;
        $display("FAIL b2b_result%0d: seen=%0d {bo,ovf,diff}=%h required %h", i, seen, act, exp_v);
      end
      if (i > 0) begin
        total++;
        if (cyc - prev_cyc !== W + 2) begin
          bad++;
          $display("FAIL b2b_spacing%0d: %0d cycles between done pulses required %0d",
                   i, cyc - prev_cyc, W + 2);
        end
      end
      prev_cyc = cyc;
      if (i == 2) bus.start = 1'b0;
    end
    repeat (W + 4) @(negedge clk);
    total++;
    if (exp_q.size() !== 0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL b2b_drain: queue=%0d state=%0d required 0 and IDLE", exp_q.size(), dbg_state);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    last_res = '0;
    test_reset();
    test_arith();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
